// File: rtl/noc_input_unit.sv
// rtl/noc_input_unit.sv - two-source round-robin NoC input FIFO with head ECC syndrome check
// Optional feature macro: NOC_INPUT_UNIT_ECC_CHECK_EN
module noc_input_unit #(
  parameter int         DEPTH      = 4,
  parameter logic [3:0] LOCAL_ADDR = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_valid,
  output logic        core_ready,
  input  logic [10:0] core_data,
  input  logic [1:0]  core_ctrl,
  input  logic        link_valid,
  output logic        link_ready,
  input  logic [10:0] link_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] out_data,
  output logic        out_local,
  output logic [4:0]  count,
  output logic        ecc_err,
  output logic [7:0]  ecc_err_cnt
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [4:0] FULL_CNT = 5'(DEPTH);

  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          rr_q, rr_d;
  logic          full, core_grant, link_grant, wr_en, rd_en;
  logic [10:0]   wr_data;

  // Fullness is judged on the registered count, so a same-cycle read never frees a slot.
  always_comb begin
    full       = (count_q == FULL_CNT);
    core_grant = !reset && !full && core_valid && (!link_valid || !rr_q);
    link_grant = !reset && !full && link_valid && (!core_valid || rr_q);
    wr_en      = link_grant || (core_grant && core_ctrl == 2'd2);
    wr_data    = link_grant ? link_data : core_data;
    rd_en      = out_valid && out_ready;

    rr_d = rr_q;
    if (!full && core_valid && link_valid) rr_d = ~rr_q;

    wr_ptr_d = wr_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    rd_ptr_d = rd_ptr_q;
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);

    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign core_ready = core_grant;
  assign link_ready = link_grant;
  assign count      = count_q;
  assign out_valid  = (count_q != 5'd0);
  assign out_data   = mem_q[rd_ptr_q];
  assign out_local  = out_valid && (out_data[3:0] == LOCAL_ADDR);

`ifdef NOC_INPUT_UNIT_ECC_CHECK_EN
  logic [6:0] r;
  logic [2:0] syndrome;
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    r        = out_data[10:4];
    syndrome = {r[3] ^ r[4] ^ r[5] ^ r[6],
                r[1] ^ r[2] ^ r[5] ^ r[6],
                r[0] ^ r[2] ^ r[4] ^ r[6]};
    err_cnt_d = err_cnt_q;
    if (rd_en && ecc_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign ecc_err     = out_valid && (syndrome != 3'd0);
  assign ecc_err_cnt = err_cnt_q;
`else
  assign ecc_err     = 1'b0;
  assign ecc_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_noc_input_unit.sv
// tb/tb_noc_input_unit.sv - randomized bench for noc_input_unit with queue-based reference model
module tb_noc_input_unit;
  localparam int         DEPTH      = 4;
  localparam logic [3:0] LOCAL_ADDR = 4'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_valid, core_ready;
  logic [10:0] core_data;
  logic [1:0]  core_ctrl;
  logic        link_valid, link_ready;
  logic [10:0] link_data;
  logic        out_valid, out_ready;
  logic [10:0] out_data;
  logic        out_local;
  logic [4:0]  count;
  logic        ecc_err;
  logic [7:0]  ecc_err_cnt;

  int errors = 0;
  int checks = 0;

  noc_input_unit #(.DEPTH(DEPTH), .LOCAL_ADDR(LOCAL_ADDR)) dut (
    .clk(clk), .reset(reset),
    .core_valid(core_valid), .core_ready(core_ready), .core_data(core_data), .core_ctrl(core_ctrl),
    .link_valid(link_valid), .link_ready(link_ready), .link_data(link_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_local(out_local),
    .count(count), .ecc_err(ecc_err), .ecc_err_cnt(ecc_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A 7-bit word has zero syndrome exactly when it is one of the 16 Hamming(7,4) codewords.
  function automatic bit is_codeword(input logic [6:0] w);
    logic [6:0] cw;
    logic [3:0] d;
    for (int i = 0; i < 16; i++) begin
      d  = 4'(i);
      cw = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
      if (cw == w) return 1'b1;
    end
    return 1'b0;
  endfunction

  logic [10:0] mq[$];
  bit          m_rr_link = 0;
  int          m_err_cnt = 0;

  always @(negedge clk) begin
    bit full, exp_cr, exp_lr, head_err, rd, wr;
    if (reset) begin
      mq.delete();
      m_rr_link = 0;
      m_err_cnt = 0;
    end
    full   = (mq.size() == DEPTH);
    exp_cr = 0;
    exp_lr = 0;
    if (!reset && !full) begin
      if (core_valid && link_valid) begin
        exp_cr = !m_rr_link;
        exp_lr = m_rr_link;
      end else begin
        exp_cr = core_valid;
        exp_lr = link_valid;
      end
    end
    head_err = 0;
`ifdef NOC_INPUT_UNIT_ECC_CHECK_EN
    if (mq.size() != 0) head_err = !is_codeword(mq[0][10:4]);
`endif
    chk("count", 32'(count), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    chk("out_local", 32'(out_local), 32'(mq.size() != 0 && mq[0][3:0] == LOCAL_ADDR));
    chk("core_ready", 32'(core_ready), 32'(exp_cr));
    chk("link_ready", 32'(link_ready), 32'(exp_lr));
    chk("ecc_err", 32'(ecc_err), 32'(head_err));
    chk("ecc_err_cnt", 32'(ecc_err_cnt), 32'(m_err_cnt));
    if (!reset) begin
      rd = (mq.size() != 0) && out_ready;
      wr = exp_lr || (exp_cr && core_ctrl == 2'd2);
      if (rd && head_err && m_err_cnt < 255) m_err_cnt++;
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(exp_lr ? link_data : core_data);
      if (!full && core_valid && link_valid) m_rr_link = !m_rr_link;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; core_valid = 1; core_data = 11'h003; core_ctrl = 2'd2;
    link_valid = 0; link_data = '0; out_ready = 0;
    chk("model_cw_zero", 32'(is_codeword(7'h00)), 32'd1);
    chk("model_cw_043", 32'(is_codeword(7'h04)), 32'd0);
    tick(); tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_core_ready", 32'(core_ready), 32'd0);
    chk("rst_ecc_cnt", 32'(ecc_err_cnt), 32'd0);

    reset = 0; #1;
    chk("first_core_ready", 32'(core_ready), 32'd1);
    tick();
    core_valid = 0;
    chk("first_out_valid", 32'(out_valid), 32'd1);
    chk("first_out_data", 32'(out_data), 32'h003);
    chk("first_count", 32'(count), 32'd1);
    chk("first_out_local", 32'(out_local), 32'd0);
    out_ready = 1; tick(); out_ready = 0;
    chk("drain_count", 32'(count), 32'd0);

    core_valid = 1; core_ctrl = 2'd1; core_data = 11'h005; #1;
    chk("discard_ready", 32'(core_ready), 32'd1);
    tick();
    core_valid = 0;
    chk("discard_count", 32'(count), 32'd0);
    chk("discard_out_valid", 32'(out_valid), 32'd0);

    core_valid = 1; core_ctrl = 2'd2; core_data = 11'h001;
    link_valid = 1; link_data = 11'h002; out_ready = 1; #1;
    chk("rr0_core", 32'(core_ready), 32'd1);
    chk("rr0_link", 32'(link_ready), 32'd0);
    tick();
    chk("rr_out0", 32'(out_data), 32'h001);
    chk("rr1_core", 32'(core_ready), 32'd0);
    chk("rr1_link", 32'(link_ready), 32'd1);
    tick();
    chk("rr_out1", 32'(out_data), 32'h002);
    chk("rr2_core", 32'(core_ready), 32'd1);
    chk("rr2_link", 32'(link_ready), 32'd0);
    tick();
    chk("rr_out2", 32'(out_data), 32'h001);
    core_valid = 0; link_valid = 0;
    tick();
    out_ready = 0;
    chk("rr_drain", 32'(count), 32'd0);

    link_valid = 1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      link_data = 11'(16 + i); #1;
      chk("fill_link_ready", 32'(link_ready), 32'(i < DEPTH));
      tick();
    end
    chk("full_count", 32'(count), 32'(DEPTH));
    out_ready = 1; #1;
    chk("full_read_link_ready", 32'(link_ready), 32'd0);
    tick();
    out_ready = 0; link_valid = 0;
    chk("after_read_count", 32'(count), 32'(DEPTH - 1));

    reset = 1; #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    tick();
    reset = 0;

`ifdef NOC_INPUT_UNIT_ECC_CHECK_EN
    link_valid = 1; link_data = 11'h043; #1;
    tick();
    link_data = 11'h003;
    tick();
    link_valid = 0;
    chk("ecc_err_043", 32'(ecc_err), 32'd1);
    chk("ecc_cnt_pre", 32'(ecc_err_cnt), 32'd0);
    out_ready = 1; #1;
    tick();
    out_ready = 0;
    chk("ecc_cnt_one", 32'(ecc_err_cnt), 32'd1);
    chk("ecc_err_003", 32'(ecc_err), 32'd0);
    out_ready = 1; tick();
    link_valid = 1; link_data = 11'h043;
    repeat (300) tick();
    link_valid = 0;
    tick();
    out_ready = 0;
    chk("ecc_cnt_sat", 32'(ecc_err_cnt), 32'd255);
`else
    link_valid = 1; link_data = 11'h043; #1;
    tick();
    link_valid = 0;
    chk("ecc_err_off", 32'(ecc_err), 32'd0);
    chk("ecc_cnt_off", 32'(ecc_err_cnt), 32'd0);
    out_ready = 1; tick(); out_ready = 0;
`endif

    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 249) == 0);
      core_valid = $urandom_range(0, 1);
      core_ctrl  = 2'($urandom_range(0, 3));
      core_data  = 11'($urandom);
      link_valid = ($urandom_range(0, 2) != 0);
      link_data  = 11'($urandom);
      out_ready  = ($urandom_range(0, 3) < (i % 600 < 300 ? 1 : 3));
      tick();
    end
    reset = 0; core_valid = 0; link_valid = 0; out_ready = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/noc_input_unit.md
NOC_INPUT_UNIT -- requirements
Module: noc_input_unit

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 4, giving the FIFO depth in packets; legal values are powers of two, 2..16.
REQ-002 The block SHALL have a parameter LOCAL_ADDR, default 4'h0, giving this node's 4-bit IP.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 core_valid  in  1  core packet offered.
REQ-007 core_ready  out  1  core packet consumed this cycle.
REQ-008 core_data  in  11  core packet: [3:0] IP, [10:4] Hamming(7,4) field.
REQ-009 core_ctrl  in  2  core control code; 2'd2 means store the packet.
REQ-010 link_valid  in  1  neighbour-router packet offered.
REQ-011 link_ready  out  1  link packet consumed this cycle.
REQ-012 link_data  in  11  link packet, same format as core_data.
REQ-013 out_valid  out  1  FIFO head valid.
REQ-014 out_ready  in  1  downstream accepts the head.
REQ-015 out_data  out  11  FIFO head packet.
REQ-016 out_local  out  1  high when out_data[3:0] equals LOCAL_ADDR.
REQ-017 count  out  5  FIFO occupancy, 0..DEPTH.
REQ-018 ecc_err  out  1  head packet has a nonzero Hamming syndrome.
REQ-019 ecc_err_cnt  out  8  count of erroneous packets read out.

Function
REQ-020 A transfer on a source SHALL occur on a rising edge when its valid and ready are both high; the output transfer SHALL occur when out_valid and out_ready are both high.
REQ-021 Ready SHALL be computed combinationally: both readies SHALL be low when count==DEPTH, measured before the current cycle's read (no full-bypass).
REQ-022 When not full and only one source is valid, only that source's ready SHALL be high.
REQ-023 When not full and both sources are valid, only the source selected by a 1-bit round-robin pointer SHALL be ready; the pointer SHALL toggle after each contended grant and SHALL hold otherwise.
REQ-024 A granted core packet with core_ctrl==2 SHALL be written to the FIFO tail.
REQ-025 A granted core packet with core_ctrl!=2 SHALL be consumed and discarded: no write, no count change.
REQ-026 A granted link packet SHALL always be written.
REQ-027 At most one write SHALL occur per cycle.
REQ-028 out_valid SHALL equal (count!=0), and out_data SHALL be the head entry.
REQ-029 Minimum latency SHALL be one cycle: a packet written at edge N is visible on out_data after edge N; there is no input-to-output combinational path.
REQ-030 A simultaneous read and write SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-031 out_local SHALL be combinational from out_data[3:0] and SHALL be 0 when out_valid is 0.
REQ-032 FIFO order SHALL be strict arrival order across both sources.

Reset
REQ-033 While reset is high: count=0, pointers=0, round-robin pointer=core, out_valid=0, core_ready=0, link_ready=0, ecc_err=0, ecc_err_cnt=0.
REQ-034 A reset asserted mid-operation SHALL discard all stored packets immediately; FIFO memory contents need not be cleared.

Configuration
REQ-035 Macro NOC_INPUT_UNIT_ECC_CHECK_EN: when defined, the syndrome is computed on head bits r[6:0]=out_data[10:4]:
- s1=r0^r2^r4^r6, s2=r1^r2^r5^r6, s4=r3^r4^r5^r6;
- ecc_err = out_valid & (syndrome!=0);
- ecc_err_cnt increments on each output transfer with ecc_err=1 and saturates at 255.
REQ-036 When the macro is undefined, ecc_err and ecc_err_cnt SHALL be tied to 0 and no syndrome logic SHALL be built; the port list SHALL be unchanged.

Verification
REQ-037 Reset release, core_valid=1, core_ctrl=2, core_data=11'h003, out_ready=0 -> next cycle out_valid=1, out_data=11'h003, count=1, out_local=0 (LOCAL_ADDR=0).
REQ-038 Core sends 11'h005 with core_ctrl=1 -> core_ready=1, count stays 0, out_valid stays 0.
REQ-039 Both sources valid continuously (core 11'h001, link 11'h002), out_ready=1 -> grants alternate core,link,core, and the output sequence is 001,002,001.
REQ-040 out_ready=0 and DEPTH+1 link packets offered -> count=4, link_ready=0 on the fifth; then one read with a link offer -> no write that cycle, count=3.
REQ-041 With the macro defined: head 11'h043 read -> ecc_err=1 and ecc_err_cnt 0->1; head 11'h003 -> ecc_err=0. 256 erroneous reads -> ecc_err_cnt=255.
REQ-042 Reset asserted with count=3 -> out_valid=0 and count=0 asynchronously, before the next clock edge.
